// File: rtl/mb32_seq_r4.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, product = mx*my (optional MB_SEQ_SIGNED_EN: two's complement).
// Latency ITER cycles from accept to out_valid; out_valid/product hold while out_ready is low, in_ready drops meanwhile.
// Backpressure: in_ready = IDLE || (DONE && out_ready), so a new pair may be accepted on the handoff edge.
`timescale 1ns/1ps

module mb32_seq_r4 #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

`ifdef MB_SEQ_SIGNED_EN
    localparam int ITER = WIDTH / 2;
`else
    localparam int ITER = (WIDTH + 2) / 2;
`endif
    localparam int YW = 2 * ITER;           // multiplier bits consumed
    localparam int HW = WIDTH + 3;          // accumulator upper half
    localparam int AW = HW + YW;            // full accumulator
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         m_q, m_d;
    logic [YW:0]           y_q, y_d;        // bit 0 carries y[-1]
    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    prod_q, prod_d;

    logic                  accept;
    logic [HW-1:0]         m_ext;
    logic [YW:0]           y_ext;
    logic [HW-1:0]         addend;
    logic [HW-1:0]         hi_sum;
    logic signed [AW-1:0]  acc_sh;
    logic [AW-1:0]         acc_step;

    assign accept = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!RST) begin
            in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        end
    end

    // operand extension chosen by build configuration
    always_comb begin
`ifdef MB_SEQ_SIGNED_EN
        m_ext = {{3{mx[WIDTH-1]}}, mx};
        y_ext = {my, 1'b0};
`else
        m_ext = {3'b000, mx};
        y_ext = {2'b00, my, 1'b0};
`endif
    end

    // Booth digit decode on window {y[2i+1], y[2i], y[2i-1]}
    always_comb begin
        addend = '0;
        case (y_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = {m_q[HW-2:0], 1'b0};
            3'b100:         addend = ~{m_q[HW-2:0], 1'b0} + HW'(1);
            3'b101, 3'b110: addend = ~m_q + HW'(1);
            default:        addend = '0;
        endcase
    end

    always_comb begin
        hi_sum   = acc_q[AW-1 -: HW] + addend;
        acc_sh   = $signed({hi_sum, acc_q[YW-1:0]}) >>> 2;
        acc_step = acc_sh;
    end

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (accept)         state_d = S_BUSY;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY);
        product   = prod_q;
    end

    // datapath next values
    always_comb begin
        m_d    = m_q;
        y_d    = y_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (accept) begin
            m_d   = m_ext;
            y_d   = y_ext;
            acc_d = '0;
            cnt_d = CW'(ITER);
        end else if (state_q == S_BUSY) begin
            acc_d = acc_step;
            y_d   = y_q >> 2;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                prod_d = acc_step[2*WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            m_q    <= m_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: tb/tb_mb32_seq_r4.sv
// Directed bench for mb32_seq_r4: scoreboard of expected products, latency/spacing and handshake checks.
`timescale 1ns/1ps

module tb_mb32_seq_r4;

`ifdef MB_SEQ_SIGNED_EN
    localparam int ITER = 16;
`else
    localparam int ITER = 17;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mx;
    logic [31:0] my;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    mb32_seq_r4 #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mx        (mx),
        .my        (my),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [63:0] exp_q[$];
    longint      acc_cyc_q[$];
    bit          b2b = 1'b0;
    bit          have_ho = 1'b0;
    longint      last_ho = 0;
    bit          prev_ov = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MB_SEQ_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // output monitor: latency on rising out_valid, scoreboard pop on handoff
    always @(negedge CLK) begin
        logic [63:0] e;
        if (RST) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_cyc_q.size() == 0)
                    check64("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                else
                    check64("latency", 64'(cyc - acc_cyc_q[0]), 64'(ITER));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check64("unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_cyc_q.pop_front());
                    check64("product", product, e);
                    if (b2b && have_ho)
                        check64("b2b_spacing", 64'(cyc - last_ho), 64'(ITER + 1));
                    last_ho = cyc;
                    have_ho = 1'b1;
                end
            end
            prev_ov = out_valid;
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        mx = a;
        my = b;
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            check64("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            exp_q.push_back(model(a, b));
            acc_cyc_q.push_back(cyc + 1);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        check64("drain", 64'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        int n;
        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mx = '0;
        my = '0;
        repeat (3) @(posedge CLK);
        #1;
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_product", product, 64'd0);
        check64("rst_busy", {63'd0, busy}, 64'd0);
        check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check64("idle_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge CLK);
        #1;

        send(32'd0, 32'd0);
        drain();
        check64("zero_product", product, 64'd0);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
`ifdef MB_SEQ_SIGNED_EN
        check64("neg1_sq", product, 64'd1);
`else
        check64("ones_sq", product, 64'hFFFF_FFFE_0000_0001);
`endif
        send(32'h0001_0000, 32'h0000_FFFF);
        drain();
        check64("shift_const", product, 64'h0000_0000_FFFF_0000);

        send(32'h8000_0000, 32'h8000_0000);
        drain();
        check64("msb_sq", product, 64'h4000_0000_0000_0000);
        send(32'hFFFF_FFF9, 32'd3);
        drain();
`ifdef MB_SEQ_SIGNED_EN
        check64("neg7x3", product, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        check64("neg7x3_unsigned", product, 64'h0000_0002_FFFF_FFEB);
`endif

        // idle hold: no new op, product and out_valid stable
        e = product;
        repeat (4) begin
            @(negedge CLK);
            check64("idle_out_valid", {63'd0, out_valid}, 64'd0);
            check64("idle_hold", product, e);
        end
        @(posedge CLK);
        #1;

        // sparse sweep over 0..655350000 in multiples of 10000
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                send(32'(i * 43690000), 32'(j * 43690000));
        drain();

        // back-to-back spacing
        b2b = 1'b1;
        have_ho = 1'b0;
        send(32'd17, 32'd19);
        send(32'hDEAD_BEEF, 32'h1234_5678);
        send(32'h7FFF_FFFF, 32'h8000_0001);
        send(32'd1, 32'hFFFF_FFFF);
        drain();
        b2b = 1'b0;

        // backpressure in DONE
        out_ready = 1'b0;
        send(32'd123456789, 32'd987654321);
        e = model(32'd123456789, 32'd987654321);
        n = 0;
        @(negedge CLK);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge CLK);
        end
        repeat (10) begin
            check64("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check64("bp_product", product, e);
            check64("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge CLK);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check64("bp_handoff", {63'd0, out_valid}, 64'd0);
        check64("bp_queue", 64'(exp_q.size()), 64'd0);

        // reset mid-BUSY
        send(32'd1234, 32'd5678);
        repeat (7) @(posedge CLK);
        #1;
        check64("pre_rst_busy", {63'd0, busy}, 64'd1);
        RST = 1'b1;
        #1;
        check64("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("midrst_product", product, 64'd0);
        check64("midrst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        repeat (ITER + 3) begin
            @(negedge CLK);
            check64("post_rst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        @(posedge CLK);
        #1;
        send(32'd3, 32'd5);
        drain();
        check64("after_rst_3x5", product, 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
